bcd2_seg_scan: RTL and testbench
================================

Name: bcd2_seg_scan

Overview:
Downstream display stage for the ×5 BCD multiplier. It consumes the two-digit BCD result (tens d, units u) and drives a two-digit, common-anode, time-multiplexed 7-segment display. Digits are captured on a load strobe and scanned alternately with a programmable refresh period. A blanking gap between digits prevents ghosting. Options cover leading-zero suppression and invalid-BCD flagging.

Parameters:
REFRESH_DIV, 50000, clock cycles each digit is lit per scan phase (≥1)
DEAD_CYC, 16, clock cycles both anodes are off between digit phases (≥1)
BLANK_LZ, 1, 1 = tens digit fully dark when latched tens = 0

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
load  input  1  capture strobe; d/u sampled on rising clk edge while high
d  input  4  BCD tens digit from multiplier
u  input  4  BCD units digit from multiplier
seg  output  7  segment drive {g,f,e,d,c,b,a}, active-high, registered
an  output  2  digit enables, active-low; an[0] = units, an[1] = tens, registered
err  output  1  sticky flag: last loaded value had a digit > 9, registered

Behaviour:
- Reset (rst_n low, asynchronous): d_q = 0, u_q = 0, err = 0, seg = 7'h00, an = 2'b11, state = DEAD_TO_U, phase counter = 0. Reset overrides load.
- Latch: at each edge with load = 1, d_q ← d and u_q ← u. err ← (d > 9) | (u > 9); both digits valid clears err. Load = 0 leaves d_q, u_q and err unchanged. Load does not disturb the scan counter or state.
- FSM states, with a phase counter cnt:
  - SHOW_U: REFRESH_DIV cycles, then DEAD_TO_T.
  - DEAD_TO_T: DEAD_CYC cycles, then SHOW_T.
  - SHOW_T: REFRESH_DIV cycles, then DEAD_TO_U.
  - DEAD_TO_U: DEAD_CYC cycles, then SHOW_U.
- cnt resets to 0 on every state change and counts up to (length − 1). The transition occurs on the edge where cnt = length − 1.
- Full scan period = 2·(REFRESH_DIV + DEAD_CYC) cycles. No drift across wrap-around.
- seg and an are registered from next-state and next-latch values. They take their new values on the same edge the state changes or a load is captured, so load-to-display latency is 1 edge when in a SHOW phase.
- SHOW_U: an = 2'b10, seg = enc(u_q).
- SHOW_T: an = 2'b01, seg = enc(d_q). Exception: BLANK_LZ = 1 and d_q = 0 gives an = 2'b11, seg = 7'h00.
- DEAD states: an = 2'b11, seg = 7'h00.
- enc(x), by digit value:
  - 0 → 3F, 1 → 06, 2 → 5B, 3 → 4F, 4 → 66
  - 5 → 6D, 6 → 7D, 7 → 07, 8 → 7F, 9 → 6F
  - any value 10–15 → 40 (dash, g only)
- Invalid digit: displayed as dash, never blanked. err stays high until a fully valid load.
- Load during a DEAD phase: captured immediately; shown at the next SHOW phase.
- Load on the same edge as a state transition: the new phase shows the newly loaded value.
- an is never 2'b00 in any cycle, including across reset release.
- Reset asserted mid-scan: outputs return to reset values immediately, without waiting for clk.

Test Plan (REFRESH_DIV=4, DEAD_CYC=1, BLANK_LZ=1):
1. Release rst_n, no load. Expect an = 11, seg = 00 for 1 edge. Then SHOW_U: an = 10, seg = 3F for 4 cycles. Then an = 11 for 1 cycle. SHOW_T is dark (tens = 0): an = 11. Scan period = 10 cycles.
2. Pulse load with d = 3, u = 5 (i = 7 result). Expect units phase seg = 6D, an = 10, and tens phase seg = 4F, an = 01. err = 0.
3. Load d = 4, u = 5 mid-SHOW_U. Expect seg unchanged to 6D on the next edge (units). The next SHOW_T shows 66.
4. Load d = 0, u = 0. Expect units 3F, tens dark. Repeat with BLANK_LZ = 0: tens shows 3F with an = 01.
5. Load d = 12, u = 5. Expect err = 1 and tens phase seg = 40, an = 01. Then load d = 1, u = 0: err = 0, tens seg = 06.
6. Assert rst_n low mid-SHOW_T, asynchronous to clk. Expect seg = 00, an = 11, err = 0 immediately. After release, the step-1 sequence repeats.

Source files
------------

// File: rtl/bcd2_seg_scan.sv
// Two-digit common-anode 7-segment scanner for a BCD pair (tens d, units u).
// Digits are latched on load and shown alternately, with dark gaps between phases.
module bcd2_seg_scan #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned DEAD_CYC    = 16,
    parameter int unsigned BLANK_LZ    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] d,
    input  logic [3:0] u,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       err
);

    localparam int unsigned MAX_LEN = (REFRESH_DIV > DEAD_CYC) ? REFRESH_DIV : DEAD_CYC;
    localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1);
    localparam logic [CNT_W-1:0] REF_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYC - 1);

    typedef enum logic [1:0] {
        SHOW_U    = 2'd0,
        DEAD_TO_T = 2'd1,
        SHOW_T    = 2'd2,
        DEAD_TO_U = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       d_q, u_q, d_n, u_n;
    logic             err_n;
    logic [6:0]       seg_n;
    logic [1:0]       an_n;

    // Segment pattern {g,f,e,d,c,b,a}; non-BCD values render as a dash.
    function automatic logic [6:0] enc(input logic [3:0] x);
        case (x)
            4'd0:    enc = 7'h3F;
            4'd1:    enc = 7'h06;
            4'd2:    enc = 7'h5B;
            4'd3:    enc = 7'h4F;
            4'd4:    enc = 7'h66;
            4'd5:    enc = 7'h6D;
            4'd6:    enc = 7'h7D;
            4'd7:    enc = 7'h07;
            4'd8:    enc = 7'h7F;
            4'd9:    enc = 7'h6F;
            default: enc = 7'h40;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= DEAD_TO_U;
            cnt   <= '0;
            d_q   <= 4'd0;
            u_q   <= 4'd0;
            err   <= 1'b0;
            seg   <= 7'h00;
            an    <= 2'b11;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            d_q   <= d_n;
            u_q   <= u_n;
            err   <= err_n;
            seg   <= seg_n;
            an    <= an_n;
        end
    end

    // Next scan state, next latch, and display drive derived from both.
    always_comb begin
        state_n = state;
        cnt_n   = cnt + CNT_W'(1);
        d_n     = d_q;
        u_n     = u_q;
        err_n   = err;
        seg_n   = 7'h00;
        an_n    = 2'b11;

        if (load) begin
            d_n   = d;
            u_n   = u;
            err_n = (d > 4'd9) | (u > 4'd9);
        end

        case (state)
            SHOW_U: if (cnt == REF_LAST) begin
                state_n = DEAD_TO_T;
                cnt_n   = '0;
            end
            DEAD_TO_T: if (cnt == DEAD_LAST) begin
                state_n = SHOW_T;
                cnt_n   = '0;
            end
            SHOW_T: if (cnt == REF_LAST) begin
                state_n = DEAD_TO_U;
                cnt_n   = '0;
            end
            default: if (cnt == DEAD_LAST) begin
                state_n = SHOW_U;
                cnt_n   = '0;
            end
        endcase

        // Driving from next values gives one-edge latency on load and phase change.
        case (state_n)
            SHOW_U: begin
                an_n  = 2'b10;
                seg_n = enc(u_n);
            end
            SHOW_T: begin
                if (!((BLANK_LZ != 0) && (d_n == 4'd0))) begin
                    an_n  = 2'b01;
                    seg_n = enc(d_n);
                end
            end
            default: begin
                an_n  = 2'b11;
                seg_n = 7'h00;
            end
        endcase
    end

endmodule

// File: tb/tb_bcd2_seg_scan.sv
// Directed bench for bcd2_seg_scan: scan-position model checked every cycle
// on two instances (leading-zero blanking on and off), plus literal spot checks.
module tb_bcd2_seg_scan;

    localparam int unsigned R = 4;
    localparam int unsigned D = 1;
    localparam int P = 2 * (R + D);

    logic       clk;
    logic       rst_n;
    logic       load;
    logic [3:0] d, u;
    logic [6:0] seg1, seg0;
    logic [1:0] an1, an0;
    logic       err1, err0;

    int total = 0;
    int bad   = 0;

    bcd2_seg_scan #(.REFRESH_DIV(R), .DEAD_CYC(D), .BLANK_LZ(1)) dut_blank (
        .clk(clk), .rst_n(rst_n), .load(load), .d(d), .u(u),
        .seg(seg1), .an(an1), .err(err1)
    );

    bcd2_seg_scan #(.REFRESH_DIV(R), .DEAD_CYC(D), .BLANK_LZ(0)) dut_plain (
        .clk(clk), .rst_n(rst_n), .load(load), .d(d), .u(u),
        .seg(seg0), .an(an0), .err(err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: edge count since reset release -> position in the scan period.
    int         k  = 0;
    logic [3:0] md = 4'd0;
    logic [3:0] mu = 4'd0;
    logic       me = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k  <= 0;
            md <= 4'd0;
            mu <= 4'd0;
            me <= 1'b0;
        end else begin
            k <= k + 1;
            if (load) begin
                md <= d;
                mu <= u;
                me <= (d > 9) || (u > 9);
            end
        end
    end

    function automatic logic [6:0] glyph(input logic [3:0] x);
        logic [6:0] tab [10];
        tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        if (x > 9) return 7'h40;
        return tab[x];
    endfunction

    // Expected {seg, an}; the reset position is the start of the gap before units.
    function automatic logic [8:0] expect_out(input bit blank, input int kk,
                                              input logic [3:0] dd, input logic [3:0] uu);
        int pos;
        pos = (P - int'(D) + kk) % P;
        if (pos < int'(R)) return {glyph(uu), 2'b10};
        if (pos >= int'(R + D) && pos < int'(2 * R + D)) begin
            if (blank && dd == 4'd0) return {7'h00, 2'b11};
            return {glyph(dd), 2'b01};
        end
        return {7'h00, 2'b11};
    endfunction

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [8:0] e1, e0;
        e1 = expect_out(1'b1, k, md, mu);
        e0 = expect_out(1'b0, k, md, mu);
        chk("model_seg_blank", {1'b0, seg1}, {1'b0, e1[8:2]});
        chk("model_an_blank",  {6'd0, an1},  {6'd0, e1[1:0]});
        chk("model_err_blank", {7'd0, err1}, {7'd0, me});
        chk("model_seg_plain", {1'b0, seg0}, {1'b0, e0[8:2]});
        chk("model_an_plain",  {6'd0, an0},  {6'd0, e0[1:0]});
        chk("model_err_plain", {7'd0, err0}, {7'd0, me});
        total++;
        if (an1 == 2'b00 || an0 == 2'b00) begin
            bad++;
            $display("FAIL both_anodes_on an1=%b an0=%b at %0t", an1, an0, $time);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_load(input logic [3:0] dv, input logic [3:0] uv);
        load = 1'b1;
        d    = dv;
        u    = uv;
        tick(1);
        load = 1'b0;
    endtask

    task automatic startup_seq(input string tag);
        chk({tag, "_pre_an"},  {6'd0, an1}, 8'h03);
        chk({tag, "_pre_seg"}, {1'b0, seg1}, 8'h00);
        tick(1);
        chk({tag, "_u_an"},  {6'd0, an1}, 8'h02);
        chk({tag, "_u_seg"}, {1'b0, seg1}, 8'h3F);
        tick(4);
        chk({tag, "_gap_an"}, {6'd0, an1}, 8'h03);
        tick(1);
        chk({tag, "_tdark_an"},  {6'd0, an1}, 8'h03);
        chk({tag, "_tdark_seg"}, {1'b0, seg1}, 8'h00);
        tick(5);
        chk({tag, "_wrap_an"},  {6'd0, an1}, 8'h02);
        chk({tag, "_wrap_seg"}, {1'b0, seg1}, 8'h3F);
    endtask

    initial begin
        rst_n = 1'b1;
        load  = 1'b0;
        d     = 4'd0;
        u     = 4'd0;
        #1 rst_n = 1'b0;
        tick(2);
        chk("rst_seg", {1'b0, seg1}, 8'h00);
        chk("rst_an",  {6'd0, an1}, 8'h03);
        chk("rst_err", {7'd0, err1}, 8'h00);
        rst_n = 1'b1;

        // Step 1: power-up scan, tens dark, period 10.
        startup_seq("s1");

        // Step 2: 35 shown on both digits (edge 11 -> 12 is pos 1).
        pulse_load(4'd3, 4'd5);
        chk("s2_u_seg", {1'b0, seg1}, 8'h6D);
        chk("s2_u_an",  {6'd0, an1}, 8'h02);
        chk("s2_err",   {7'd0, err1}, 8'h00);
        tick(5);
        chk("s2_t_seg", {1'b0, seg1}, 8'h4F);
        chk("s2_t_an",  {6'd0, an1}, 8'h01);

        // Step 3: reload mid units phase.
        tick(5);
        pulse_load(4'd4, 4'd5);
        chk("s3_u_seg", {1'b0, seg1}, 8'h6D);
        tick(4);
        chk("s3_t_seg", {1'b0, seg1}, 8'h66);

        // Step 4: 00 loaded during tens phase: blank vs. plain instance.
        pulse_load(4'd0, 4'd0);
        chk("s4_t_an_blank",  {6'd0, an1}, 8'h03);
        chk("s4_t_seg_blank", {1'b0, seg1}, 8'h00);
        chk("s4_t_an_plain",  {6'd0, an0}, 8'h01);
        chk("s4_t_seg_plain", {1'b0, seg0}, 8'h3F);
        tick(4);
        chk("s4_u_seg", {1'b0, seg1}, 8'h3F);

        // Step 5: invalid tens, then recovery.
        pulse_load(4'd12, 4'd5);
        chk("s5_err_set", {7'd0, err1}, 8'h01);
        chk("s5_u_seg",   {1'b0, seg1}, 8'h6D);
        tick(4);
        chk("s5_t_seg", {1'b0, seg1}, 8'h40);
        chk("s5_t_an",  {6'd0, an1}, 8'h01);
        pulse_load(4'd1, 4'd0);
        chk("s5_err_clr", {7'd0, err1}, 8'h00);
        chk("s5_t_seg1",  {1'b0, seg1}, 8'h06);

        // Load during the gap, then load on a phase-change edge.
        tick(1);
        pulse_load(4'd7, 4'd2);
        chk("gap_an",  {6'd0, an1}, 8'h03);
        chk("gap_seg", {1'b0, seg1}, 8'h00);
        tick(1);
        chk("gap_then_u", {1'b0, seg1}, 8'h5B);
        tick(3);
        tick(1);
        pulse_load(4'd9, 4'd8);
        chk("edge_load_t_seg", {1'b0, seg1}, 8'h6F);
        chk("edge_load_t_an",  {6'd0, an1}, 8'h01);

        // Step 6: asynchronous reset in the middle of the tens phase.
        tick(1);
        #2 rst_n = 1'b0;
        #1;
        chk("s6_seg", {1'b0, seg1}, 8'h00);
        chk("s6_an",  {6'd0, an1}, 8'h03);
        chk("s6_err", {7'd0, err1}, 8'h00);
        tick(1);
        rst_n = 1'b1;
        startup_seq("s6");

        tick(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
